// File: rtl/apb4_master_pkg.sv
// Shared types for the APB4 multi-completer requester: FSM states and queue payloads.
// Payload fields are sized for the widest legal configuration and narrowed at use.
package apb4_master_pkg;

  localparam int unsigned CMD_AW = 32;
  localparam int unsigned CMD_DW = 32;
  localparam int unsigned CMD_SW = 4;
  localparam int unsigned CMD_IW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [CMD_SW-1:0] strb;
    logic [2:0]        prot;
    logic [CMD_IW-1:0] idx;
    logic              dec_err;
  } cmd_t;

  typedef struct packed {
    logic [CMD_DW-1:0] rdata;
    logic              err;
    logic              write;
  } rsp_t;

endpackage

// File: rtl/apb_fwft_fifo.sv
// First-word-fall-through FIFO with an occupancy counter so every entry is usable.
module apb_fwft_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_pclk,
  input  logic                   i_prst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_WIDTH'(1);
      if (do_pop)  rptr <= rptr + PTR_WIDTH'(1);
      if (do_push && !do_pop)      count <= count + CNT_WIDTH'(1);
      else if (!do_push && do_pop) count <= count - CNT_WIDTH'(1);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge i_pclk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/apb4_multi_master.sv
// Queued APB4 requester driving NUM_SLV one-hot-selected completers with in-order responses.
// Optional ACCESS timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb4_multi_master
  import apb4_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned NUM_SLV        = 4,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          i_pclk,
  input  logic                          i_prst_n,
  input  logic                          i_req,
  output logic                          o_ready,
  input  logic                          i_rw,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [DATA_WIDTH/8-1:0]       i_strb,
  input  logic [2:0]                    i_prot,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic                          o_rsp_write,
  output logic                          o_busy,
  output logic [NUM_SLV-1:0]            o_psel,
  output logic                          o_penable,
  output logic                          o_pwrite,
  output logic [ADDR_WIDTH-1:0]         o_paddr,
  output logic [DATA_WIDTH-1:0]         o_pwdata,
  output logic [DATA_WIDTH/8-1:0]       o_pstrb,
  output logic [2:0]                    o_pprot,
  input  logic [NUM_SLV-1:0]            i_pready,
  input  logic [NUM_SLV-1:0]            i_pslverr,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] i_prdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SEL_BITS   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CMD_WIDTH  = $bits(cmd_t);
  localparam int unsigned RSP_WIDTH  = $bits(rsp_t);

  state_t                       state;
  logic [SEL_BITS-1:0]          cur_idx;
  logic                         cur_write;

  cmd_t                         cmd_in;
  cmd_t                         cmd_head;
  logic                         cmd_push;
  logic                         cmd_pop;
  logic                         cmd_full;
  logic                         cmd_empty;
  logic [$clog2(CMD_DEPTH):0]   cmd_count;

  rsp_t                         rsp_in;
  rsp_t                         rsp_head;
  logic                         rsp_push;
  logic                         rsp_pop;
  logic                         rsp_full;
  logic                         rsp_empty;
  logic [$clog2(RSP_DEPTH):0]   rsp_count;

  logic [SEL_BITS-1:0]          dec_idx;
  logic [SEL_BITS-1:0]          head_idx;
  logic                         load;
  logic                         xfer_end;
  logic                         sel_ready;
  logic                         sel_err;
  logic [DATA_WIDTH-1:0]        sel_rdata;
  logic [DATA_WIDTH-1:0]        prdata_arr [NUM_SLV];

  // Command capture: decode once at enqueue, reads never carry strobes.
  assign dec_idx  = i_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign cmd_push = i_req && !cmd_full;
  assign o_ready  = !cmd_full;

  always_comb begin
    cmd_in         = '0;
    cmd_in.rw      = i_rw;
    cmd_in.addr    = CMD_AW'(i_addr);
    cmd_in.wdata   = CMD_DW'(i_wdata);
    cmd_in.strb    = CMD_SW'(i_rw ? i_strb : STRB_WIDTH'(0));
    cmd_in.prot    = i_prot;
    cmd_in.idx     = CMD_IW'(dec_idx);
    cmd_in.dec_err = (32'(dec_idx) >= NUM_SLV);
  end

  apb_fwft_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_pclk   (i_pclk),
    .i_prst_n (i_prst_n),
    .push     (cmd_push),
    .wdata    (cmd_in),
    .pop      (cmd_pop),
    .rdata    (cmd_head),
    .full     (cmd_full),
    .empty    (cmd_empty),
    .count    (cmd_count)
  );

  apb_fwft_fifo #(.WIDTH(RSP_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .i_pclk   (i_pclk),
    .i_prst_n (i_prst_n),
    .push     (rsp_push),
    .wdata    (rsp_in),
    .pop      (rsp_pop),
    .rdata    (rsp_head),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .count    (rsp_count)
  );

  // Response side: fields read as zero whenever nothing is queued.
  assign rsp_pop     = o_rsp_valid && i_rsp_ready;
  assign o_rsp_valid = !rsp_empty;
  assign o_rsp_rdata = o_rsp_valid ? DATA_WIDTH'(rsp_head.rdata) : '0;
  assign o_rsp_err   = o_rsp_valid && rsp_head.err;
  assign o_rsp_write = o_rsp_valid && rsp_head.write;
  assign o_busy      = (state != IDLE) || (cmd_count != '0);

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_prdata
    assign prdata_arr[k] = i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign head_idx  = SEL_BITS'(cmd_head.idx);
  assign sel_ready = i_pready[cur_idx];
  assign sel_err   = i_pslverr[cur_idx];
  assign sel_rdata = prdata_arr[cur_idx];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 tmo_hit;

  assign tmo_hit  = (state == ACCESS) && !sel_ready && (32'(tmo_cnt) == TIMEOUT_CYCLES - 1);
  assign xfer_end = (state == ACCESS) && (sel_ready || tmo_hit);

  // Counts ACCESS cycles of the current transfer; every SETUP restarts it.
  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n)             tmo_cnt <= '0;
    else if (state == SETUP)   tmo_cnt <= '0;
    else if (state == ACCESS)  tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
  end
`else
  assign xfer_end = (state == ACCESS) && sel_ready;
`endif

  // Queue handshakes: decode errors bypass the bus, completions may chain into SETUP.
  always_comb begin
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    load     = 1'b0;
    rsp_in   = '0;
    case (state)
      IDLE: begin
        if (!cmd_empty && !rsp_full) begin
          cmd_pop = 1'b1;
          if (cmd_head.dec_err) begin
            rsp_push     = 1'b1;
            rsp_in.err   = 1'b1;
            rsp_in.write = cmd_head.rw;
          end else begin
            load = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_push     = 1'b1;
          rsp_in.rdata = cur_write ? CMD_DW'(0) : CMD_DW'(sel_rdata);
          rsp_in.err   = sel_err;
          rsp_in.write = cur_write;
          if (!cmd_empty && !cmd_head.dec_err &&
              ((32'(rsp_count) + 32'd1) < (RSP_DEPTH + 32'(rsp_pop)))) begin
            cmd_pop = 1'b1;
            load    = 1'b1;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_push     = 1'b1;
          rsp_in.err   = 1'b1;
          rsp_in.write = cur_write;
        end
`endif
      end
      default: ;
    endcase
  end

  // Bus FSM with registered APB outputs held stable from SETUP to the end of ACCESS.
  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      state     <= IDLE;
      cur_idx   <= '0;
      cur_write <= 1'b0;
      o_psel    <= '0;
      o_penable <= 1'b0;
      o_pwrite  <= 1'b0;
      o_paddr   <= '0;
      o_pwdata  <= '0;
      o_pstrb   <= '0;
      o_pprot   <= '0;
    end else if (load) begin
      state     <= SETUP;
      cur_idx   <= head_idx;
      cur_write <= cmd_head.rw;
      o_psel    <= NUM_SLV'(1) << head_idx;
      o_penable <= 1'b0;
      o_pwrite  <= cmd_head.rw;
      o_paddr   <= ADDR_WIDTH'(cmd_head.addr);
      o_pwdata  <= DATA_WIDTH'(cmd_head.wdata);
      o_pstrb   <= STRB_WIDTH'(cmd_head.strb);
      o_pprot   <= cmd_head.prot;
    end else begin
      case (state)
        SETUP: begin
          state     <= ACCESS;
          o_penable <= 1'b1;
        end
        ACCESS: begin
          if (xfer_end) begin
            state     <= IDLE;
            o_psel    <= '0;
            o_penable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
